// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding, counter width and retry helper for the PLL reset sequencer
package pll_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  // Retry counter increments but sticks at its maximum value
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer, both stages reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values simply shift the asynchronous input down the chain
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Two-stage register chain giving metastability settling time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset/lock sequencer; PLL_RETRY_LIMIT_EN enables the FAIL state after MAX_RETRIES
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       rst_out_n,
  output logic       pll_ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
);

`ifdef PLL_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT cycle that first sees lock_s high counts as the first stable
  // cycle, so SETTLE only has to cover the remaining STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

  logic             lock_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             fail_attempt;

  sync_2ff u_lock_sync (
    .clk   (clkin),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // State, cycle counter and retry counter registers
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic; restart overrides every other transition
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    fail_attempt = 1'b0;

    if (restart) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_d = (STABLE_CYCLES <= 1) ? ST_RUN : ST_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            fail_attempt = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            // Lock lost before it proved stable: keep waiting, not a retry
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            fail_attempt = 1'b1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase

      if (fail_attempt) begin
        retry_d = sat_inc4(retry_q);
        cnt_d   = '0;
        state_d = (LIMIT_EN && (retry_d == RETRY_LIMIT)) ? ST_FAIL : ST_HOLD;
      end
    end
  end

  // Outputs decode straight from the state register so they change on the
  // same edge as the state and take their reset values asynchronously.
  assign pll_reset = (state_q == ST_HOLD);
  assign rst_out_n = (state_q == ST_RUN);
  assign pll_ready = (state_q == ST_RUN);
`ifdef PLL_RETRY_LIMIT_EN
  assign fault     = (state_q == ST_FAIL);
`else
  assign fault     = 1'b0;
`endif
  assign retry_cnt = retry_q;
  assign state_o   = state_q;

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of clkin cycles pll_reset is held high per attempt (range 1..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096: number of clkin cycles to wait for lock before retrying (range 1..65535).
REQ-003 SHALL have parameter STABLE_CYCLES, default 256: number of consecutive synchronized-lock-high cycles required before release (range 1..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: number of failed attempts tolerated, used only under PLL_RETRY_LIMIT_EN (range 1..15).
REQ-005 SHALL have port clkin, input, 1 bit: reference clock (the PLL input clock); single clock domain.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port pll_lock, input, 1 bit: PLL LOCK output, asynchronous to clkin.
REQ-008 SHALL have port restart, input, 1 bit: synchronous single-cycle request to re-sequence the PLL.
REQ-009 SHALL have port pll_reset, output, 1 bit: drives the PLL RESET pin, active-high.
REQ-010 SHALL have port rst_out_n, output, 1 bit: active-low reset request for the PLL-clocked logic.
REQ-011 SHALL have port pll_ready, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port fault, output, 1 bit: high only in state FAIL.
REQ-013 SHALL have port retry_cnt, output, 4 bits: number of failed attempts since reset_n or restart, saturating at 15.
REQ-014 SHALL have port state_o, output, 3 bits: current state encoding.

Function
REQ-015 SHALL pass pll_lock through a 2-flop synchronizer (lock_s), giving 2 cycles of latency; all decisions SHALL use lock_s only.
REQ-016 SHALL implement states HOLD=0, WAIT=1, SETTLE=2, RUN=3, FAIL=4 with a single 16-bit cycle counter cnt.
REQ-017 HOLD SHALL assert pll_reset for exactly RST_CYCLES cycles, then go to WAIT with cnt cleared.
REQ-018 In WAIT, lock_s=1 SHALL go to SETTLE with cnt=0; if cnt reaches LOCK_TIMEOUT-1 without lock, the block SHALL count a failed attempt.
REQ-019 In SETTLE, lock_s=0 SHALL return to WAIT with cnt=0 and SHALL NOT count a retry; STABLE_CYCLES consecutive lock_s=1 cycles SHALL go to RUN.
REQ-020 In RUN, lock_s=0 for one cycle SHALL count a failed attempt, and rst_out_n SHALL fall on the same edge as the state change.
REQ-021 A failed attempt SHALL increment retry_cnt (saturating) and go to HOLD, or go to FAIL when the limit applies (REQ-028).
REQ-022 rst_out_n SHALL be 1 only in RUN; pll_reset SHALL be 1 only in HOLD.
REQ-023 restart=1 in any state SHALL go to HOLD, clear cnt and clear retry_cnt; restart has priority over all other transitions in the same cycle.
REQ-024 FAIL SHALL be exited only by restart or reset_n.

Reset
REQ-025 While reset_n=0, the block SHALL hold state=HOLD, cnt=0, retry_cnt=0, synchronizer flops=0, pll_reset=1, rst_out_n=0, pll_ready=0, fault=0.
REQ-026 After reset_n deasserts, the block SHALL begin the HOLD count on the first clkin edge; reset_n asserted mid-sequence SHALL abort immediately to the REQ-025 values.

Configuration
REQ-027 Macro PLL_RETRY_LIMIT_EN SHALL select the retry limit behaviour.
REQ-028 With PLL_RETRY_LIMIT_EN defined, a failed attempt that makes retry_cnt equal to MAX_RETRIES SHALL go to FAIL instead of HOLD.
REQ-029 Without PLL_RETRY_LIMIT_EN, the block SHALL retry forever, FAIL SHALL be unreachable, and fault SHALL be tied to 0.

Structure
REQ-030 State encoding constants and the counter width constant (16) SHALL live in the shared package pll_seq_pkg.
REQ-031 The synchronizer SHALL be the sub-module sync_2ff (1-bit, reset value 0).

Verification (bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, macro defined unless stated)
REQ-032 Scenario: release reset_n, then raise pll_lock 10 cycles later -> pll_reset high for 4 cycles; rst_out_n rises 2+8 cycles after lock; pll_ready=1; retry_cnt=0.
REQ-033 Scenario: pll_lock glitches low for 1 cycle at SETTLE cycle 5 -> state returns to WAIT, retry_cnt stays 0, and RUN is reached 8 cycles after lock_s returns high.
REQ-034 Scenario: pll_lock held at 0 -> two 20-cycle timeouts, retry_cnt=1 then 2, state=FAIL, fault=1, pll_reset=0; with the macro undefined, HOLD/WAIT cycle indefinitely and retry_cnt saturates at 15.
REQ-035 Scenario: in RUN, drop pll_lock -> rst_out_n falls 3 cycles later (2 sync + 1), pll_reset high for 4 cycles, retry_cnt=1.
REQ-036 Scenario: restart pulse in FAIL and in RUN -> next state HOLD, retry_cnt=0, rst_out_n=0.
REQ-037 Scenario: assert reset_n mid-SETTLE -> outputs take the REQ-025 values asynchronously, without waiting for a clkin edge.
